// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared types and constants for the Wishbone SDRAM-port arbiter.
package wb_arb_pkg;

    localparam int unsigned MAX_M = 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ERR_WAIT
    } arb_state_e;

endpackage

// File: rtl/wb_sdram_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned PW    = 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NUM_M-1:0] winner,
    output logic             valid
);

    // Offsets are walked in priority order; the inner loop keeps every index constant.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            for (int unsigned j = 0; j < NUM_M; j++) begin
                if (!valid && req[j] && (((32'(ptr) + i) % NUM_M) == j)) begin
                    winner[j] = 1'b1;
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the SDRAM controller slave port.
// Optional stall watchdog compiled in with `define WB_ARB_WATCHDOG_EN.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_addr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]      m_cti_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [2:0]              s_cti_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    if (NUM_M < 2 || NUM_M > MAX_M) begin : g_bad_num_m
        $error("wb_sdram_arbiter: NUM_M must be 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_sdram_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_e       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    ptr_next;
    logic [NUM_M-1:0] pick_winner;
    logic             pick_valid;
    logic             g_cyc;
    logic             g_stb;
    logic             stall_to;

`ifdef WB_ARB_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] wd_q, wd_d;
`endif

    rr_priority_picker #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_picker (
        .req    (m_cyc_i),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign g_cyc    = m_cyc_i[gidx];
    assign g_stb    = m_stb_i[gidx];
    assign ptr_next = (gidx == PW'(NUM_M - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        stall_to = 1'b0;
`ifdef WB_ARB_WATCHDOG_EN
        wd_d     = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    state_d = GRANT;
`ifdef WB_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            GRANT: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
`ifdef WB_ARB_WATCHDOG_EN
                else if (g_stb && !s_ack_i && (wd_q == CW'(TIMEOUT - 1))) begin
                    stall_to = 1'b1;
                    state_d  = ERR_WAIT;
                end else if (s_ack_i) begin
                    wd_d = '0;
                end else if (g_stb) begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
`ifdef WB_ARB_WATCHDOG_EN
            ERR_WAIT: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Slave side is only driven while a grant is live; ERR_WAIT and IDLE park it at zero.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        if (state_q == GRANT) begin
            s_cyc_o       = g_cyc & ~stall_to;
            s_stb_o       = g_stb & ~stall_to;
            s_we_o        = m_we_i[gidx];
            s_addr_o      = m_addr_i[gidx*AW +: AW];
            s_dat_o       = m_dat_i[gidx*DW +: DW];
            s_sel_o       = m_sel_i[gidx*SW +: SW];
            s_cti_o       = m_cti_i[gidx*3 +: 3];
            m_ack_o[gidx] = s_ack_i;
            m_err_o[gidx] = stall_to;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef WB_ARB_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
`ifdef WB_ARB_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

endmodule

// File: doc/wb_sdram_arbiter.md
# wb_sdram_arbiter

Round-robin Wishbone B3 arbiter sharing the single Wishbone slave port of the SDRAM controller among NUM_M masters. Sits between the masters and the controller on the wb_clk_i domain, grants one master per bus cycle, routes ack/data back, and holds the grant for the whole cycle, including incrementing bursts. An optional watchdog terminates stalled cycles with an error.

## Interface
- NUM_M, 2, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- TIMEOUT, 1024, watchdog limit in cycles (only with watchdog compiled in)
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i, m_stb_i, m_we_i  in  NUM_M each  per-master strobes
- m_addr_i  in  NUM_M*AW  packed, master k at [k*AW +: AW]
- m_dat_i  in  NUM_M*DW  packed write data
- m_sel_i  in  NUM_M*DW/8  packed byte selects
- m_cti_i  in  NUM_M*3  packed cycle type
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NUM_M  per-master ack
- m_err_o  out  NUM_M  per-master error (watchdog)
- s_cyc_o, s_stb_o, s_we_o  out  1  to controller
- s_addr_o  out  AW;  s_dat_o  out  DW;  s_sel_o  out  DW/8;  s_cti_o  out  3
- s_dat_i  in  DW;  s_ack_i  in  1  from controller
- grant_o  out  NUM_M  one-hot registered grant, all-zero when idle

## Operation
- States: IDLE, GRANT, ERR_WAIT (ERR_WAIT exists only with watchdog).
- IDLE: all s_* outputs 0, grant_o=0. If any m_cyc_i is high, the picker selects the first requesting master searching from ptr; grant_o loads it, state -> GRANT.
- GRANT (master g): s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g], s_we/addr/dat/sel/cti muxed combinationally from g; m_ack_o[g]=s_ack_i, all other acks 0; m_dat_o=s_dat_i always.
- Grant held while m_cyc_i[g] high, regardless of cti or stb gaps; bursts (cti=3'b010) are never split.
- m_cyc_i[g] low -> state IDLE, ptr=(g+1) mod NUM_M.
- Reset: ptr=0, state IDLE, grant_o=0, all m_ack_o/m_err_o/s_* outputs 0 immediately (async); a cycle in flight is dropped.
- Non-granted masters see ack=0, err=0 and wait; no queueing beyond cyc held high.
- s_ack_i is ignored while IDLE.

## Timing
- Arbitration latency: m_cyc_i rising sampled at edge t -> s_cyc_o high during cycle t+1 (one cycle).
- Release: cyc drop sampled at edge t -> IDLE in cycle t+1; new grant earliest in cycle t+2 (one dead cycle, guaranteeing s_cyc_o falls between owners).
- Simultaneous requests in IDLE: lowest index at or after ptr wins; with ptr=0 after reset, master 0 wins.
- Requests arriving in the release cycle are arbitrated in the following IDLE cycle with the updated ptr.
- Ack/data path purely combinational; no added latency per beat.
- s_cyc_o equals s_stb_o whenever the granted master obeys cyc==stb (WB rule 3.25 preserved).

## Configuration
- WB_ARB_WATCHDOG_EN defined: counter cleared on grant and on every s_ack_i; increments each GRANT cycle with s_stb_o=1 and s_ack_i=0. When it reaches TIMEOUT-1: m_err_o[g] pulses one cycle, s_cyc_o/s_stb_o forced 0, state -> ERR_WAIT; ERR_WAIT holds s_* at 0 until m_cyc_i[g] low, then IDLE with ptr advanced.
- Undefined: no counter, no ERR_WAIT, m_err_o tied 0; a stalled cycle holds the grant indefinitely.

## Structure
- wb_arb_pkg: state enum (IDLE, GRANT, ERR_WAIT), CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111), NUM_M upper bound.
- Sub-module rr_priority_picker: combinational, inputs req[NUM_M] and ptr, output one-hot winner and valid.

## Test plan
- Reset mid-burst: master 0 granted, assert wb_rst_i -> same cycle s_cyc_o=0, grant_o=0; after release master 1 request alone -> grant_o=2'b10 next cycle.
- Simultaneous m_cyc_i=2'b11 after reset -> master 0 granted; after its cyc drops, one dead cycle, then master 1 granted (grant_o=2'b10).
- Master 1 8-beat INCR burst (cti 010..., last 111) while master 0 requests -> all 8 acks to master 1, m_ack_o[0]=0 throughout, master 0 granted 2 cycles after master 1 drops cyc.
- NUM_M=4, masters 0,2,3 continuously requesting single cycles -> grant order 0,2,3,0,2,3.
- WB_ARB_WATCHDOG_EN, TIMEOUT=16, controller never acks -> m_err_o[g] pulses after 16 stalled cycles, s_cyc_o low until master drops cyc.
- Without macro, same stall for 2000 cycles -> grant held, m_err_o always 0.
